// File: rtl/lane_queue_sensor.sv
// lane_queue_sensor: per-lane debounced arrival/departure counting with
// registered S1/S5 threshold flags and sticky overflow/underflow errors.
module lane_queue_sensor #(
   parameter int CNT_W = 4,
   parameter int DEB   = 4,
   parameter int TH1   = 1,
   parameter int TH5   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arr_ns,
   input  logic             arr_sn,
   input  logic             arr_ew,
   input  logic             arr_we,
   input  logic             dep_ns,
   input  logic             dep_sn,
   input  logic             dep_ew,
   input  logic             dep_we,
   input  logic             clr_err,
   output logic             S1_NS,
   output logic             S1_SN,
   output logic             S1_EW,
   output logic             S1_WE,
   output logic             S5_NS,
   output logic             S5_SN,
   output logic             S5_EW,
   output logic             S5_WE,
   output logic [CNT_W-1:0] cnt_ns,
   output logic [CNT_W-1:0] cnt_sn,
   output logic [CNT_W-1:0] cnt_ew,
   output logic [CNT_W-1:0] cnt_we,
   output logic [3:0]       ovf,
   output logic [3:0]       udf
);
   localparam logic [CNT_W-1:0] MAX = '1;
   logic [7:0] raw, ev;
   logic [3:0] inc, dec, ovf_set, udf_set, s1, s5, s1_nx, s5_nx;
   logic [3:0][CNT_W-1:0] cnt, cnt_nx;
   // channels 0..3 are arrivals, 4..7 departures, lane order NS, SN, EW, WE
   assign raw = {dep_we, dep_ew, dep_sn, dep_ns, arr_we, arr_ew, arr_sn, arr_ns};
   for (genvar i = 0; i < 8; i++) begin : g_ch
      logic [1:0] sync;
      logic       lvl, lvl_d;
      logic [3:0] stab;
      always_ff @(posedge clk or negedge rst)
         if (!rst) begin
            sync  <= '0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
            stab  <= '0;
         end else begin
            sync  <= {sync[0], raw[i]};
            lvl_d <= lvl;
            if (sync[1] == lvl) stab <= '0;
            else if (stab == 4'(DEB - 1)) begin
               lvl  <= sync[1];
               stab <= '0;
            end else stab <= stab + 4'd1;
         end
      assign ev[i] = lvl & ~lvl_d;
   end
   // coincident arrival and departure cancel, including their error flags
   assign inc = ev[3:0] & ~ev[7:4];
   assign dec = ev[7:4] & ~ev[3:0];
   always_comb begin
      ovf_set = '0;
      udf_set = '0;
      s1_nx   = '0;
      s5_nx   = '0;
      cnt_nx  = cnt;
      for (int j = 0; j < 4; j++) begin
         ovf_set[j] = inc[j] && cnt[j] == MAX;
         udf_set[j] = dec[j] && cnt[j] == '0;
         cnt_nx[j]  = (inc[j] && !ovf_set[j]) ? cnt[j] + 1'b1 :
                      (dec[j] && !udf_set[j]) ? cnt[j] - 1'b1 : cnt[j];
         s1_nx[j]   = cnt_nx[j] >= CNT_W'(TH1);
         s5_nx[j]   = cnt_nx[j] >= CNT_W'(TH5);
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt <= '0;
         s1  <= '0;
         s5  <= '0;
         ovf <= '0;
         udf <= '0;
      end else begin
         cnt <= cnt_nx;
         s1  <= s1_nx;
         s5  <= s5_nx;
         ovf <= (ovf & ~{4{clr_err}}) | ovf_set;
         udf <= (udf & ~{4{clr_err}}) | udf_set;
      end
   assign {cnt_we, cnt_ew, cnt_sn, cnt_ns} = cnt;
   assign {S1_WE, S1_EW, S1_SN, S1_NS} = s1;
   assign {S5_WE, S5_EW, S5_SN, S5_NS} = s5;
endmodule
